sfq_line_arbiter: RTL and testbench
===================================

# sfq_line_arbiter

Synchronous scheduler that shares one buffered SFQ line between N_REQ requesters. Each requester posts pulse requests. The arbiter queues them per requester and grants one pulse per slot, round-robin. It enforces a minimum spacing of HOLDOFF cycles between emitted pulses, which models the buffer cell's critical timing window. The emitted pulse is edge-encoded: q toggles once per granted pulse, matching the toggle-output convention of the buffer cell it drives.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- CNT_W, 3, width of each per-requester pending counter (max 2^CNT_W-1 queued pulses)
- HOLDOFF, 4, minimum cycles between successive q toggles (>=1; 1 = one toggle per cycle allowed)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req  in  N_REQ  one-cycle pulse request per requester; several bits may be high at once
- en  in  1  scheduling enable; when low, no grants are issued but requests still queue
- ovf_clr  in  1  clears all ovf bits
- q  out  1  edge-encoded line output; toggles once per granted pulse
- grant  out  N_REQ  one-hot, high for exactly the cycle in which that requester's pulse is emitted
- busy  out  1  high while any pending counter is nonzero or holdoff is running
- ovf  out  N_REQ  sticky flag per requester; set when a request is dropped at saturation

## Operation
- State per requester: pend[i] (CNT_W bits).
- Shared state:
  - hold (counter, width clog2(HOLDOFF)+1)
  - ptr (round-robin pointer, clog2(N_REQ) bits)
  - q
- Reset values: q=0, grant=0, busy=0, ovf=0, pend=0, hold=0, ptr=0.
- Per cycle (all updates at the rising edge):
  - Eligibility: eligible[i] = (pend[i]!=0). A grant fires when en=1, hold==0 and any bit of eligible is set.
  - Winner selection: the winner is the first eligible index at or after ptr, wrapping modulo N_REQ.
  - On a grant to w:
    - grant=onehot(w)
    - q toggles
    - pend[w] decrements
    - ptr is set to (w+1) mod N_REQ
    - hold is loaded with HOLDOFF-1
  - Without a grant: grant=0; if hold!=0, hold decrements.
- Request accounting:
  - req[i] with no grant to i: pend[i]+1.
  - req[i] in the same cycle as a grant to i: pend[i] is unchanged (net zero).
  - Saturation: req[i] while pend[i]==max and no grant to i drops the request and sets ovf[i].
- Flag precedence: ovf_clr clears all ovf bits. If ovf_clr and a new overflow occur in the same cycle, the bit ends set.
- busy is registered: busy = (any pend!=0) or (hold!=0), evaluated on next-state values.
- en low: hold still counts down and ptr is frozen.
- Reset mid-operation: all queued pulses are discarded and q returns to 0. This toggle counts as an edge on the line. The downstream cell must be reset in the same cycle.

## Timing
- A request sampled at edge k is queued at edge k. The earliest grant and q toggle occur at edge k+1, so latency is 1 cycle when idle.
- Spacing: consecutive q toggles are at least HOLDOFF cycles apart, e.g. edges k+1 and k+1+HOLDOFF.
- Throughput is one pulse per HOLDOFF cycles, shared across all requesters.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro: SFQ_LINE_ARB_FIXED_PRIO_EN.
- Defined: winner is the lowest eligible index (fixed priority). ptr is not implemented.
- Undefined (default): round-robin, as specified above.
- All other behaviour is identical in both builds.

## Structure
- Shared package sfq_arb_pkg holds:
  - default parameter constants N_REQ, CNT_W, HOLDOFF
  - a clog2 helper function
  - typedef pend_t for the pending-counter vector
- One sub-module, sfq_arb_pick: purely combinational picker.
  - Inputs: eligible, ptr. Output: one-hot winner.
  - The macro selects its round-robin or fixed-priority body.
- The top level contains the counters, hold, q and the flags.

## Test plan
- Reset: assert rst for 2 cycles mid-traffic -> q=0, grant=0, busy=0, ovf=0. After reset with no req, q stays constant for 20 cycles.
- Single request, HOLDOFF=4: req[2] at edge 10 -> grant=0100 and q toggles at edge 11; busy drops at edge 14.
- Simultaneous requests: req=1111 at edge 5, round-robin build -> grants to 0,1,2,3 at edges 6,10,14,18; q makes 4 toggles.
- Fixed-priority build: requests 0 and 3 pending, with req[0] re-posted after each grant -> requester 0 is always granted first.
- Saturation, CNT_W=3, en=0: 8 pulses on req[1] -> pend[1]=7 and ovf[1]=1. Then set en=1 -> exactly 7 grants. ovf_clr -> ovf=0.
- Request and grant in the same cycle: pend[0]=1 and req[0] arrives on the grant edge -> pend[0] stays 1 and the next grant follows exactly HOLDOFF cycles later.

Source files
------------

// File: rtl/sfq_arb_pkg.sv
// sfq_arb_pkg: shared constants and helpers for the SFQ line arbiter.
// Contents: default parameter values, a ceiling-log2 helper, and the
// pending-counter vector type sized for the default configuration.
// Build option: SFQ_LINE_ARB_FIXED_PRIO_EN (fixed-priority picker) is
// consumed by sfq_arb_pick and sfq_line_arbiter, not here.
package sfq_arb_pkg;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_CNT_W   = 3;
    localparam int DEF_HOLDOFF = 4;

    // Ceiling log2, with a minimum of 1 so that any select built from it
    // is at least one bit wide.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

    typedef logic [DEF_N_REQ-1:0][DEF_CNT_W-1:0] pend_t;

endpackage

// File: rtl/sfq_line_arbiter_if.sv
// sfq_line_arbiter_if: request/line bundle between the requesters and the
// arbiter.
//   req     requester -> arbiter  one-cycle pulse request per requester
//   en      requester -> arbiter  scheduling enable
//   ovf_clr requester -> arbiter  clear all sticky overflow flags
//   q       arbiter -> line       edge-encoded output, toggles per pulse
//   grant   arbiter -> requester  one-hot, high on the emitting cycle
//   busy    arbiter -> requester  work queued or holdoff running
//   ovf     arbiter -> requester  sticky per-requester drop flag
// Modports: master = requester side, slave = arbiter side.
interface sfq_line_arbiter_if
    import sfq_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ
);
    logic [N_REQ-1:0] req;
    logic             en;
    logic             ovf_clr;
    logic             q;
    logic [N_REQ-1:0] grant;
    logic             busy;
    logic [N_REQ-1:0] ovf;

    modport master (output req, en, ovf_clr, input q, grant, busy, ovf);
    modport slave  (input req, en, ovf_clr, output q, grant, busy, ovf);
endinterface

// File: rtl/sfq_arb_pick.sv
// sfq_arb_pick: combinational winner picker.
//   elig_i  per-requester eligibility (pending count nonzero)
//   ptr_i   round-robin start index
//   win_o   one-hot winner, all zero when nothing is eligible
// Build option SFQ_LINE_ARB_FIXED_PRIO_EN: lowest eligible index wins and
// ptr_i is ignored; otherwise the first eligible index at or after ptr_i,
// wrapping modulo N_REQ, wins.
module sfq_arb_pick
    import sfq_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int PTR_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] elig_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] win_o
);

    logic             found;
    logic [PTR_W-1:0] idx;

`ifdef SFQ_LINE_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;

    always_comb begin
        win_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = PTR_W'(k);
            if (!found && elig_i[idx]) begin
                win_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
`else
    always_comb begin
        win_o = '0;
        found = 1'b0;
        idx   = '0;
        // Walk the ring starting at ptr_i; the first eligible index wins.
        for (int k = 0; k < N_REQ; k++) begin
            idx = PTR_W'((int'(ptr_i) + k) % N_REQ);
            if (!found && elig_i[idx]) begin
                win_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/sfq_line_arbiter.sv
// sfq_line_arbiter: shares one buffered SFQ line between N_REQ requesters.
// Requests are counted per requester, one pulse is granted per slot, and
// successive q toggles are kept at least HOLDOFF cycles apart.
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  sfq_line_arbiter_if.slave (req, en, ovf_clr in; q, grant, busy, ovf out)
// Build option SFQ_LINE_ARB_FIXED_PRIO_EN: fixed priority (lowest index),
// no round-robin pointer. Default is round-robin.
module sfq_line_arbiter
    import sfq_arb_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int HOLDOFF = DEF_HOLDOFF
) (
    input  logic               clk,
    input  logic               rst,
    sfq_line_arbiter_if.slave  bus
);

    localparam int                PTR_W     = clog2(N_REQ);
    localparam int                HOLD_W    = clog2(HOLDOFF) + 1;
    localparam logic [CNT_W-1:0]  PEND_MAX  = '1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF - 1);

    logic [N_REQ-1:0][CNT_W-1:0] pend_q, pend_d;
    logic [HOLD_W-1:0]           hold_q, hold_d;
    logic                        q_q, q_d;
    logic                        busy_q, busy_d;
    logic [N_REQ-1:0]            grant_q, grant_d;
    logic [N_REQ-1:0]            ovf_q, ovf_d;
    logic [N_REQ-1:0]            new_ovf;
    logic [N_REQ-1:0]            elig, win;
    logic                        fire;
    logic [PTR_W-1:0]            ptr_pick;

`ifdef SFQ_LINE_ARB_FIXED_PRIO_EN
    assign ptr_pick = '0;
`else
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] widx;
    assign ptr_pick = ptr_q;
`endif

    always_comb begin
        elig = '0;
        for (int i = 0; i < N_REQ; i++) elig[i] = (pend_q[i] != '0);
    end

    sfq_arb_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
        .elig_i (elig),
        .ptr_i  (ptr_pick),
        .win_o  (win)
    );

    assign fire = bus.en && (hold_q == '0) && (|elig);

    always_comb begin
        grant_d = fire ? win : '0;
        q_d     = q_q ^ fire;
        pend_d  = pend_q;
        new_ovf = '0;
        // A request and a grant to the same requester cancel out.
        for (int i = 0; i < N_REQ; i++) begin
            if (bus.req[i] && !grant_d[i]) begin
                if (pend_q[i] == PEND_MAX) new_ovf[i] = 1'b1;
                else                       pend_d[i]  = pend_q[i] + CNT_W'(1);
            end else if (!bus.req[i] && grant_d[i]) begin
                pend_d[i] = pend_q[i] - CNT_W'(1);
            end
        end
        // A fresh overflow wins over a simultaneous clear.
        ovf_d = (bus.ovf_clr ? '0 : ovf_q) | new_ovf;

        if (fire)              hold_d = HOLD_LOAD;
        else if (hold_q != '0) hold_d = hold_q - HOLD_W'(1);
        else                   hold_d = hold_q;

        busy_d = (|pend_d) || (hold_d != '0);
    end

`ifndef SFQ_LINE_ARB_FIXED_PRIO_EN
    always_comb begin
        widx = '0;
        for (int i = 0; i < N_REQ; i++) if (win[i]) widx = PTR_W'(i);
        ptr_d = ptr_q;
        if (fire) ptr_d = (widx == PTR_W'(N_REQ - 1)) ? '0 : widx + PTR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q  <= '0;
            hold_q  <= '0;
            q_q     <= 1'b0;
            busy_q  <= 1'b0;
            grant_q <= '0;
            ovf_q   <= '0;
        end else begin
            pend_q  <= pend_d;
            hold_q  <= hold_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
            grant_q <= grant_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.q     = q_q;
    assign bus.grant = grant_q;
    assign bus.busy  = busy_q;
    assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_sfq_line_arbiter.sv
// Bench for sfq_line_arbiter: a vector table for directed sequences,
// hand-written multi-cycle corner cases, and random traffic compared
// against a count/timestamp reference model.
module tb_sfq_line_arbiter;
    import sfq_arb_pkg::*;

    localparam int N    = 4;
    localparam int CW   = 3;
    localparam int H    = 4;
    localparam int PMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sfq_line_arbiter_if #(.N_REQ(N)) bus();

    sfq_line_arbiter #(.N_REQ(N), .CNT_W(CW), .HOLDOFF(H)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int nvec = 0;
    int nerr = 0;

    // Reference model: pending counts as integers, spacing enforced by the
    // edge number of the last grant.
    int           m_pend[N];
    int           m_ptr;
    int           m_last;
    int           cyc = 0;
    bit           m_q, m_busy;
    bit [N-1:0]   m_grant, m_ovf;

    task automatic model_edge();
        int  w;
        bit  fire, any;
        bit [N-1:0] nov;
        cyc++;
        if (rst) begin
            foreach (m_pend[i]) m_pend[i] = 0;
            m_ptr = 0; m_last = -1000; m_q = 0; m_busy = 0; m_grant = '0; m_ovf = '0;
            return;
        end
        any = 0;
        foreach (m_pend[i]) if (m_pend[i] > 0) any = 1;
        fire = bus.en && (cyc - m_last >= H) && any;
        w = -1;
        if (fire) begin
`ifdef SFQ_LINE_ARB_FIXED_PRIO_EN
            for (int k = N - 1; k >= 0; k--) if (m_pend[k] > 0) w = k;
`else
            for (int k = N - 1; k >= 0; k--) if (m_pend[(m_ptr + k) % N] > 0) w = (m_ptr + k) % N;
`endif
        end
        nov = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.req[i] && i != w) begin
                if (m_pend[i] == PMAX) nov[i] = 1;
                else                   m_pend[i]++;
            end else if (!bus.req[i] && i == w) begin
                m_pend[i]--;
            end
        end
        m_ovf   = (bus.ovf_clr ? '0 : m_ovf) | nov;
        m_grant = '0;
        if (fire) begin
            m_grant[w] = 1;
            m_q    = !m_q;
            m_ptr  = (w + 1) % N;
            m_last = cyc;
        end
        any = 0;
        foreach (m_pend[i]) if (m_pend[i] > 0) any = 1;
        m_busy = any || (cyc - m_last < H - 1);
    endtask

    task automatic step(input logic [N-1:0] r, input logic e, input logic c, input logic rs);
        bus.req = r; bus.en = e; bus.ovf_clr = c; rst = rs;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic         en, clr, rs;
        logic         q;
        logic [N-1:0] grant;
        logic         busy;
        logic [N-1:0] ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic [N-1:0] r, logic e, logic c, logic rs,
                                logic q, logic [N-1:0] g, logic b, logic [N-1:0] o);
        vec_t v;
        v.req = r; v.en = e; v.clr = c; v.rs = rs;
        v.q = q; v.grant = g; v.busy = b; v.ovf = o;
        tbl.push_back(v);
    endfunction

    initial begin
        int ngr, gap, last_g, tog;
        logic q_prev;

        bus.req = '0; bus.en = 1'b0; bus.ovf_clr = 1'b0;

        // Directed table: inputs applied before an edge, outputs expected after it.
        add(4'b0000, 0, 0, 1,  0, 4'b0000, 0, 4'b0000);
        add(4'b0000, 0, 0, 1,  0, 4'b0000, 0, 4'b0000);
        add(4'b0100, 1, 0, 0,  0, 4'b0000, 1, 4'b0000);  // queued, idle latency 1
        add(4'b0000, 1, 0, 0,  1, 4'b0100, 1, 4'b0000);
        add(4'b0000, 1, 0, 0,  1, 4'b0000, 1, 4'b0000);
        add(4'b0000, 1, 0, 0,  1, 4'b0000, 1, 4'b0000);
        add(4'b0000, 1, 0, 0,  1, 4'b0000, 0, 4'b0000);  // holdoff expired
        add(4'b0000, 1, 0, 1,  0, 4'b0000, 0, 4'b0000);  // reset returns q to 0
        add(4'b1111, 1, 0, 0,  0, 4'b0000, 1, 4'b0000);
        add(4'b0000, 1, 0, 0,  1, 4'b0001, 1, 4'b0000);
        for (int i = 0; i < 3; i++) add(4'b0000, 1, 0, 0, 1, 4'b0000, 1, 4'b0000);
        add(4'b0000, 1, 0, 0,  0, 4'b0010, 1, 4'b0000);
        for (int i = 0; i < 3; i++) add(4'b0000, 1, 0, 0, 0, 4'b0000, 1, 4'b0000);
        add(4'b0000, 1, 0, 0,  1, 4'b0100, 1, 4'b0000);
        for (int i = 0; i < 3; i++) add(4'b0000, 1, 0, 0, 1, 4'b0000, 1, 4'b0000);
        add(4'b0000, 1, 0, 0,  0, 4'b1000, 1, 4'b0000);
        add(4'b0000, 1, 0, 0,  0, 4'b0000, 1, 4'b0000);
        add(4'b0000, 1, 0, 0,  0, 4'b0000, 1, 4'b0000);
        add(4'b0000, 1, 0, 0,  0, 4'b0000, 0, 4'b0000);
        add(4'b0001, 0, 0, 0,  0, 4'b0000, 1, 4'b0000);  // en low: queue only
        add(4'b0000, 0, 0, 0,  0, 4'b0000, 1, 4'b0000);
        add(4'b0000, 1, 0, 0,  1, 4'b0001, 1, 4'b0000);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].req, tbl[i].en, tbl[i].clr, tbl[i].rs);
            chk($sformatf("tbl[%0d] {q,grant,busy,ovf}", i),
                {bus.q, bus.grant, bus.busy, bus.ovf},
                {tbl[i].q, tbl[i].grant, tbl[i].busy, tbl[i].ovf});
        end

        // Reset for two cycles in the middle of traffic, then a quiet line.
        step(4'b0000, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(4'b1111, 1, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step(4'b1010, 1, 0, 1);
            chk("mid_reset {q,grant,busy,ovf}", {bus.q, bus.grant, bus.busy, bus.ovf}, '0);
        end
        for (int i = 0; i < 20; i++) begin
            step(4'b0000, 1, 0, 0);
            chk("post_reset_quiet {q,grant}", {bus.q, bus.grant}, '0);
        end

        // Saturation with scheduling disabled.
        step(4'b0000, 0, 0, 1);
        for (int i = 0; i < PMAX; i++) step(4'b0010, 0, 0, 0);
        chk("sat_fill {busy,ovf}", {bus.busy, bus.ovf}, {1'b1, 4'b0000});
        step(4'b0010, 0, 0, 0);
        chk("sat_drop ovf", bus.ovf, 4'b0010);
        step(4'b0010, 0, 1, 0);
        chk("clr_vs_new_ovf ovf", bus.ovf, 4'b0010);
        step(4'b0000, 0, 1, 0);
        chk("ovf_clr ovf", bus.ovf, 4'b0000);
        ngr = 0; last_g = -100; tog = 0; q_prev = bus.q;
        for (int i = 0; i < 40; i++) begin
            step(4'b0000, 1, 0, 0);
            if (bus.q !== q_prev) tog++;
            q_prev = bus.q;
            if (bus.grant != '0) begin
                ngr++;
                chk("sat_grant_id", bus.grant, 4'b0010);
                if (last_g >= 0) chk("sat_spacing", i - last_g, H);
                last_g = i;
            end
        end
        chk("sat_grant_count", ngr, PMAX);
        chk("sat_toggle_count", tog, PMAX);
        chk("sat_idle busy", bus.busy, 1'b0);

        // Request landing on its own grant edge: count holds, next grant H later.
        step(4'b0000, 0, 0, 1);
        step(4'b0001, 0, 0, 0);
        step(4'b0001, 1, 0, 0);
        chk("same_cycle grant", bus.grant, 4'b0001);
        gap = -1;
        for (int i = 1; i <= 10 && gap < 0; i++) begin
            step(4'b0000, 1, 0, 0);
            if (bus.grant != '0) gap = i;
        end
        chk("same_cycle next_gap", gap, H);
        chk("same_cycle next_grant", bus.grant, 4'b0001);
        for (int i = 0; i < H - 1; i++) step(4'b0000, 1, 0, 0);
        chk("same_cycle drained busy", bus.busy, 1'b0);

`ifdef SFQ_LINE_ARB_FIXED_PRIO_EN
        // Requester 0 re-posted after each grant keeps beating requester 3.
        step(4'b0000, 0, 0, 1);
        step(4'b1001, 0, 0, 0);
        for (int i = 0; i < 5 * H; i++) begin
            step(bus.grant[0] ? 4'b0001 : 4'b0000, 1, 0, 0);
            if (bus.grant != '0) chk("fixed_prio grant", bus.grant, 4'b0001);
        end
`endif

        // Random traffic against the reference model.
        step(4'b0000, 0, 0, 1);
        for (int i = 0; i < 800; i++) begin
            logic [N-1:0] r;
            r = '0;
            for (int b = 0; b < N; b++) r[b] = ($urandom_range(0, 3) == 0);
            step(r, $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 99) == 0);
            chk("rand {q,grant,busy,ovf}", {bus.q, bus.grant, bus.busy, bus.ovf},
                {m_q, m_grant, m_busy, m_ovf});
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
